// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined bitwise logic unit with valid/ready handshakes on both
// sides, registered zero/parity flags and a completed-transaction counter.
// Stage 1 captures the operands and the op; stage 2 evaluates the op and
// registers the result and its flags.
module logic_unit_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             parity,
    output logic [CNT_W-1:0] count
);

    // Stage 1 registers
    logic             s1_valid_reg;
    logic [2:0]       s1_op_reg;
    logic [WIDTH-1:0] s1_in1_reg;
    logic [WIDTH-1:0] s1_in2_reg;

    // Stage 2 registers
    logic             out_valid_reg;
    logic [WIDTH-1:0] out_reg;
    logic             zero_reg;
    logic             parity_reg;
    logic [CNT_W-1:0] count_reg;

    // Pipeline control
    logic             adv1;
    logic             adv2;
    logic [3:0]       op_lut;
    logic [WIDTH-1:0] result_next;

    // Stage 2 may load when it is empty or its beat leaves this cycle;
    // stage 1 may load when it is empty or it can hand over to stage 2.
    assign adv2     = !out_valid_reg || out_ready;
    assign adv1     = !s1_valid_reg || adv2;
    assign in_ready = adv1 && !rst;

    // Each op is a 2-input truth table indexed by {a, b}; one table serves
    // every bit lane, so the per-bit logic is just a 4:1 mux.
    always_comb begin
        op_lut = 4'b1100;
        case (s1_op_reg)
            3'b000:  op_lut = 4'b0011; // ~a
            3'b001:  op_lut = 4'b1000; // a & b
            3'b010:  op_lut = 4'b1110; // a | b
            3'b011:  op_lut = 4'b0110; // a ^ b
            3'b100:  op_lut = 4'b0111; // ~(a & b)
            3'b101:  op_lut = 4'b0001; // ~(a | b)
            3'b110:  op_lut = 4'b1001; // ~(a ^ b)
            default: op_lut = 4'b1100; // a
        endcase
    end

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lane
        assign result_next[gi] = op_lut[{s1_in1_reg[gi], s1_in2_reg[gi]}];
    end

    // Stage 1: capture the offered beat whenever the stage can advance
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s1_op_reg    <= 3'b000;
            s1_in1_reg   <= '0;
            s1_in2_reg   <= '0;
        end else if (adv1) begin
            s1_valid_reg <= in_valid;
            s1_op_reg    <= op;
            s1_in1_reg   <= in1;
            s1_in2_reg   <= in2;
        end
    end

    // Stage 2: register the result and flags; holds while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            out_reg       <= '0;
            zero_reg      <= 1'b0;
            parity_reg    <= 1'b0;
        end else if (adv2) begin
            out_valid_reg <= s1_valid_reg;
            out_reg       <= result_next;
            zero_reg      <= ~|result_next;
            parity_reg    <= ^result_next;
        end
    end

    // Count results accepted downstream, wrapping naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else if (out_valid_reg && out_ready) begin
            count_reg <= count_reg + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign out_valid = out_valid_reg;
    assign out       = out_reg;
    assign zero      = zero_reg;
    assign parity    = parity_reg;
    assign count     = count_reg;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe: a queue-based reference model of
// the pipeline is compared against two DUT instances (16-bit and 4-bit
// counters) on every falling edge, plus directed scenarios with literal
// expectations and a randomized phase.
module tb_logic_unit_pipe;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [2:0] op = 3'b000;
    logic [7:0] in1 = 8'h00;
    logic [7:0] in2 = 8'h00;
    logic       out_ready = 1'b0;

    logic        in_ready, out_valid, zero, parity;
    logic [7:0]  out;
    logic [15:0] count;
    logic        in_ready4, out_valid4, zero4, parity4;
    logic [7:0]  out4;
    logic [3:0]  count4;

    logic_unit_pipe #(.WIDTH(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .in1(in1), .in2(in2), .out_valid(out_valid),
        .out_ready(out_ready), .out(out), .zero(zero), .parity(parity),
        .count(count)
    );

    logic_unit_pipe #(.WIDTH(8), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
        .op(op), .in1(in1), .in2(in2), .out_valid(out_valid4),
        .out_ready(out_ready), .out(out4), .zero(zero4), .parity(parity4),
        .count(count4)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference operation straight from the op table
    function automatic logic [7:0] ref_op(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
        case (o)
            3'd0: return ~a;
            3'd1: return a & b;
            3'd2: return a | b;
            3'd3: return a ^ b;
            3'd4: return ~(a & b);
            3'd5: return ~(a | b);
            3'd6: return ~(a ^ b);
            default: return a;
        endcase
    endfunction

    // Optional hand-computed expectation travelling with the offered beat
    logic       lit_en = 1'b0;
    logic [7:0] lit_out = 8'h00;
    logic       lit_zero = 1'b0;
    logic       lit_par = 1'b0;

    typedef struct {
        logic [7:0] res;
        int         acc_edge;
        bit         has_lit;
        logic [7:0] lo;
        logic       lz;
        logic       lp;
    } beat_t;

    beat_t q[$];
    int    cnt = 0;
    int    edge_no = 0;
    bit    model_ok = 0;
    bit    last_rst = 0;

    // Compare, then advance the model to represent the upcoming rising edge
    always @(negedge clk) begin
        bit    exp_ov, exp_ir, otx, itx;
        beat_t b;
        exp_ov = (q.size() > 0) && (q[0].acc_edge < edge_no);
        exp_ir = !rst && ((q.size() < 2) || out_ready);
        if (model_ok) begin
            chk("in_ready", in_ready, exp_ir);
            chk("out_valid", out_valid, exp_ov);
            chk("count", count, cnt % 65536);
            chk("in_ready4", in_ready4, exp_ir);
            chk("out_valid4", out_valid4, exp_ov);
            chk("count4", count4, cnt % 16);
            if (exp_ov) begin
                chk("out", out, q[0].res);
                chk("zero", zero, q[0].res == 8'h00);
                chk("parity", parity, ^q[0].res);
                chk("out4", out4, q[0].res);
                if (q[0].has_lit) begin
                    chk("lit_out", out, q[0].lo);
                    chk("lit_zero", zero, q[0].lz);
                    chk("lit_parity", parity, q[0].lp);
                end
            end
            if (last_rst) begin
                chk("rst_out", out, 0);
                chk("rst_zero", zero, 0);
                chk("rst_parity", parity, 0);
            end
        end
        edge_no++;
        if (rst) begin
            q.delete();
            cnt = 0;
            model_ok = 1;
            last_rst = 1;
        end else if (model_ok) begin
            last_rst = 0;
            otx = exp_ov && out_ready;
            itx = in_valid && exp_ir;
            if (otx) begin
                void'(q.pop_front());
                cnt++;
            end
            if (itx) begin
                b.res = ref_op(op, in1, in2);
                b.acc_edge = edge_no;
                b.has_lit = lit_en;
                b.lo = lit_out;
                b.lz = lit_zero;
                b.lp = lit_par;
                q.push_back(b);
            end
        end
    end

    // Offer one beat and wait (bounded) until it is accepted
    task automatic drive_beat(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                              input bit le, input logic [7:0] lo, input logic lz, input logic lp);
        bit done;
        done = 0;
        in_valid = 1'b1; op = o; in1 = a; in2 = b;
        lit_en = le; lit_out = lo; lit_zero = lz; lit_par = lp;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (in_ready) done = 1;
            @(posedge clk);
            #1;
        end
        if (!done) chk("accept_timeout", 0, 1);
        in_valid = 1'b0;
        lit_en = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    logic [7:0] sweep_exp [8];
    int         base;

    initial begin
        sweep_exp[0] = 8'h5A; sweep_exp[1] = 8'h05; sweep_exp[2] = 8'hAF; sweep_exp[3] = 8'hAA;
        sweep_exp[4] = 8'hFA; sweep_exp[5] = 8'h50; sweep_exp[6] = 8'h55; sweep_exp[7] = 8'hA5;

        idle(3);
        rst = 1'b0;

        // Reset check: NOT of 00 gives FF, count becomes 1
        out_ready = 1'b1;
        drive_beat(3'b000, 8'h00, 8'h00, 1, 8'hFF, 1'b0, 1'b0);
        idle(3);
        chk("reset_count", count, 1);

        // All-ops sweep, back to back
        for (int i = 0; i < 8; i++)
            drive_beat(i[2:0], 8'hA5, 8'h0F, 1, sweep_exp[i], 1'b0, 1'b0);
        idle(3);

        // Zero flag
        drive_beat(3'b011, 8'h3C, 8'h3C, 1, 8'h00, 1'b1, 1'b0);
        idle(3);

        // Backpressure: two beats fill the pipe, further beats are refused
        base = count;
        out_ready = 1'b0;
        drive_beat(3'b001, 8'hFF, 8'h0F, 1, 8'h0F, 1'b0, 1'b0);
        drive_beat(3'b010, 8'hF0, 8'h0F, 1, 8'hFF, 1'b0, 1'b0);
        in_valid = 1'b1; op = 3'b111; in1 = 8'h11;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_hold", out, 8'h0F);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        idle(4);
        chk("bp_count", count, base + 2);

        // Mid-stream reset discards in-flight beats
        out_ready = 1'b0;
        drive_beat(3'b000, 8'h12, 8'h00, 0, 8'h00, 1'b0, 1'b0);
        drive_beat(3'b001, 8'h34, 8'h56, 0, 8'h00, 1'b0, 1'b0);
        do_reset();
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_count", count, 0);
        out_ready = 1'b1;
        idle(3);
        chk("mid_rst_no_stale", count, 0);
        drive_beat(3'b111, 8'h81, 8'h00, 1, 8'h81, 1'b0, 1'b0);
        idle(3);
        chk("post_rst_count", count, 1);

        // Counter wrap on the 4-bit instance
        do_reset();
        for (int i = 0; i < 17; i++)
            drive_beat(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 0, 8'h00, 1'b0, 1'b0);
        idle(4);
        chk("wrap_count4", count4, 1);
        chk("wrap_count16", count, 17);

        // Randomized traffic with random backpressure and occasional reset
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); #1;
            rst       = ($urandom_range(0, 299) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            op        = 3'($urandom_range(0, 7));
            in1       = 8'($urandom);
            in2       = 8'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
        end
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        idle(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/logic_unit_pipe.md
# logic_unit_pipe

Parametrised, two-stage pipelined bitwise logic unit; the next generation of the single-bit inverter used in the lab datapath. It applies one of eight bitwise operations (NOT, AND, OR, XOR, NAND, NOR, XNOR, PASS) to WIDTH-bit operands. It uses valid/ready handshakes on both sides, derives zero and parity flags, and keeps a completed-transaction counter. It sits between the operand register file and the ALU result mux in the lab CPU.

## Interface
- WIDTH, 8, operand/result width in bits (≥1)
- CNT_W, 16, width of the transaction counter

- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand beat offered
- in_ready  output  1  unit can accept a beat this cycle
- op  input  3  operation select, sampled with the input beat
- in1  input  WIDTH  operand A
- in2  input  WIDTH  operand B; ignored for NOT and PASS
- out_valid  output  1  result beat offered
- out_ready  input  1  consumer accepts result this cycle
- out  output  WIDTH  result
- zero  output  1  out == 0
- parity  output  1  XOR-reduction of out
- count  output  CNT_W  number of results accepted downstream, mod 2^CNT_W

## Operation
- Op encoding: 000 ~in1, 001 in1&in2, 010 in1|in2, 011 in1^in2, 100 ~(in1&in2), 101 ~(in1|in2), 110 ~(in1^in2), 111 in1.
- Stage 1 (S1) registers op, in1, in2 and s1_valid.
- Stage 2 (S2) computes the result from S1 and registers out, zero, parity and out_valid.
- Transfers:
  - Input transfer = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
- Advance rules:
  - adv2 = !out_valid | out_ready.
  - adv1 = !s1_valid | adv2.
  - in_ready = adv1 & !rst. This is combinational from out_ready.
- On adv2: S2 loads the S1 contents and out_valid <= s1_valid.
- On adv1: S1 loads the input and s1_valid <= in_valid.
- If a stage does not advance, it holds all of its registers unchanged.
- While out_valid=1 and out_ready=0, out, zero and parity are stable. Results are never dropped and never duplicated.
- count increments by 1 on every output transfer and wraps from 2^CNT_W−1 to 0.
- Flags are computed from the registered result. zero and parity are also valid when out_valid=0, but consumers must ignore them then.
- Reset: on a clk edge with rst=1, these all go to 0: s1_valid, out_valid, out, zero, parity, count and the S1 registers.
  - In-flight beats are discarded.
  - in_ready is 0 while rst=1.
- Reset mid-stream discards up to two beats. The first beat after rst deasserts is processed normally.

## Timing
- Latency: a beat accepted at edge N is presented with out_valid=1 after edge N+1 (two registers, 2 cycles input-to-output register).
- Throughput: 1 beat/cycle when out_ready is held at 1.
- Backpressure:
  - With out_ready=0, at most 2 beats are buffered (S1+S2).
  - in_ready drops to 0 in the cycle S1 and S2 are both full and out_ready=0.
- Simultaneous output transfer and input transfer with both stages full: both stages advance in the same cycle, with no bubble.
- Reset values: in_ready 0 (during rst), out_valid 0, out 0, zero 0, parity 0, count 0.

## Test plan
- Reset check: reset, then drive WIDTH=8, out_ready=1, op=000, in1=8'h00 → 2 cycles later out=8'hFF, zero=0, parity=0, count then 1.
- All-ops sweep: in1=8'hA5, in2=8'h0F, op 0..7 back-to-back → out sequence 5A,05,AF,AA,FA,50,55,A5 on consecutive cycles. Check the flags on each, e.g. op=011 gives parity=0 and zero=0.
- Zero flag: op=011, in1=in2=8'h3C → out=00, zero=1, parity=0.
- Backpressure:
  - Hold out_ready=0 and offer 4 beats → in_ready=0 after 2 accepted; out holds the first result.
  - Release out_ready → results emerge in order, none lost, count=2.
- Mid-stream reset: 2 beats in flight, assert rst 1 cycle → out_valid=0, count=0, no stale beat emerges. The next beat (op=111, in1=8'h81) yields out=81, parity=0.
- Counter wrap with CNT_W=4: 17 output transfers → count reads 1.
